// File: rtl/muldiv_ctrl.sv
// HI/LO unit for Execute: owns HI/LO, sequences a fixed-latency multiply and a
// 32-step restoring divide, and stalls the pipeline until the result lands.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT  = 3,
    parameter logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        req_ready,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX} state_t;

    state_t      state_q, state_d;
    logic        accept, is_mul, is_div, mul_sx, div_sx;
    logic [63:0] ma, mb, prod_d, prod_q;
    logic [31:0] a_mag, b_mag;
    logic [5:0]  cnt_q;
    logic [31:0] quo_q, rem_q, dvs_q, a_q;
    logic        neg_q, neg_r, dbz_q;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub, quo_fix, rem_fix;

    assign req_ready = (state_q == IDLE);
    assign stall     = req_valid & ~req_ready;
    assign accept    = req_valid & req_ready & ~flush;

    assign is_mul = (req_op == FN_MULT) | (req_op == FN_MULTU);
    assign is_div = (req_op == FN_DIV) | (req_op == FN_DIVU);
    assign mul_sx = (req_op == FN_MULT);
    assign div_sx = (req_op == FN_DIV);

    // Low 64 bits of a sign/zero-extended product are the exact result.
    assign ma     = {{32{mul_sx & req_a[31]}}, req_a};
    assign mb     = {{32{mul_sx & req_b[31]}}, req_b};
    assign prod_d = ma * mb;

    assign a_mag = (div_sx & req_a[31]) ? -req_a : req_a;
    assign b_mag = (div_sx & req_b[31]) ? -req_b : req_b;

    // Partial remainder stays below the divisor, so 32 bits hold the difference.
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_ge  = rem_sh >= {1'b0, dvs_q};
    assign rem_sub = rem_sh[31:0] - dvs_q;
    assign quo_fix = neg_q ? -quo_q : quo_q;
    assign rem_fix = neg_r ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && is_mul)      state_d = MUL_WAIT;
                else if (accept && is_div) state_d = DIV_RUN;
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 6'(MUL_LAT)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            DIV_RUN: begin
                if (flush)               state_d = IDLE;
                else if (cnt_q == 6'd31) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                done    = ~flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi     <= '0;
            lo     <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            a_q    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q  <= is_mul ? 6'd1 : 6'd0;
                        prod_q <= prod_d;
                        quo_q  <= a_mag;
                        rem_q  <= '0;
                        dvs_q  <= b_mag;
                        a_q    <= req_a;
                        neg_q  <= div_sx & (req_a[31] ^ req_b[31]);
                        neg_r  <= div_sx & req_a[31];
                        dbz_q  <= (req_b == 32'd0);
                        if (req_op == FN_MTHI) hi <= req_a;
                        if (req_op == FN_MTLO) lo <= req_a;
                    end
                end
                MUL_WAIT: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (done) {hi, lo} <= prod_q;
                end
                DIV_RUN: begin
                    cnt_q <= cnt_q + 6'd1;
                    rem_q <= rem_ge ? rem_sub : rem_sh[31:0];
                    quo_q <= {quo_q[30:0], rem_ge};
                end
                DIV_FIX: begin
                    if (done) begin
                        hi <= dbz_q ? a_q : rem_fix;
                        lo <= dbz_q ? DBZ_QUOT : quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized
// MULT/DIV traffic against an arithmetic reference model.
module tb_muldiv_ctrl;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [31:0] DBZ     = 32'hFFFF_FFFF;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [5:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;
    logic        req_ready, stall, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DBZ_QUOT(DBZ)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
        .req_ready(req_ready), .stall(stall), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} after the op, from plain arithmetic.
    function automatic logic [63:0] ref_hilo(input logic [5:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            FN_MULTU: return ua * ub;
            FN_MULT:  return 64'(sa * sb);
            FN_DIVU: begin
                if (b == 0) return {a, DBZ};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, DBZ};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Present one request for exactly one edge; leaves us in cycle 1.
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        tick();
        req_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    function automatic logic [31:0] pick_a(input int sel);
        case (sel)
            0: return 32'h8000_0000;
            1: return 32'h0;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_b(input int sel);
        case (sel)
            0: return 32'hFFFF_FFFF;
            1: return 32'h0;
            2: return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset;
        req_valid = 1'b1;
        req_op = FN_MULT;
        #2;
        checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b stall=%b done=%b want 1 0 0",
                     req_ready, stall, done);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", hi, lo);
        end
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_mult;
        logic [5:0]  ops[2] = '{FN_MULT, FN_MULTU};
        logic [63:0] want[2] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_FFFF_FFFA};
        int cyc;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'hFFFF_FFFE, 32'd3);
            wait_done(cyc);
            checks++;
            if (cyc !== MUL_LAT) begin
                errors++;
                $display("FAIL mul_lat_dir: got %0d want %0d", cyc, MUL_LAT);
            end
            tick();
            checks++;
            if ({hi, lo} !== want[i] || done !== 1'b0) begin
                errors++;
                $display("FAIL mul_dir: hi=%h lo=%h done=%b want %h done=0",
                         hi, lo, done, want[i]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            logic [5:0] op;
            logic [31:0] a, b;
            logic [63:0] exp;
            op = ($urandom_range(0, 1) == 0) ? FN_MULT : FN_MULTU;
            a = pick_a($urandom_range(0, 5));
            b = pick_b($urandom_range(0, 5));
            exp = ref_hilo(op, a, b);
            issue(op, a, b);
            wait_done(cyc);
            tick();
            checks++;
            if (cyc !== MUL_LAT || {hi, lo} !== exp) begin
                errors++;
                $display("FAIL mul_rand: op=%h a=%h b=%h lat=%0d hi=%h lo=%h want lat=%0d %h",
                         op, a, b, cyc, hi, lo, MUL_LAT, exp);
            end
        end
    endtask

    task automatic test_div;
        logic [31:0] da[2] = '{32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] db[2] = '{32'd2, 32'hFFFF_FFFF};
        logic [63:0] want[2] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000};
        int cyc;
        for (int i = 0; i < 2; i++) begin
            issue(FN_DIV, da[i], db[i]);
            wait_done(cyc);
            checks++;
            if (cyc !== DIV_LAT) begin
                errors++;
                $display("FAIL div_lat_dir: got %0d want %0d", cyc, DIV_LAT);
            end
            tick();
            checks++;
            if ({hi, lo} !== want[i]) begin
                errors++;
                $display("FAIL div_dir: hi=%h lo=%h want %h", hi, lo, want[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            logic [5:0] op;
            logic [31:0] a, b;
            logic [63:0] exp;
            op = ($urandom_range(0, 1) == 0) ? FN_DIV : FN_DIVU;
            a = pick_a($urandom_range(0, 5));
            b = pick_b($urandom_range(0, 6));
            exp = ref_hilo(op, a, b);
            issue(op, a, b);
            wait_done(cyc);
            tick();
            checks++;
            if (cyc !== DIV_LAT || {hi, lo} !== exp) begin
                errors++;
                $display("FAIL div_rand: op=%h a=%h b=%h lat=%0d hi=%h lo=%h want lat=%0d %h",
                         op, a, b, cyc, hi, lo, DIV_LAT, exp);
            end
        end
    endtask

    task automatic test_dbz;
        int cyc;
        issue(FN_DIVU, 32'h0000_1234, 32'h0);
        wait_done(cyc);
        checks++;
        if (cyc !== DIV_LAT) begin
            errors++;
            $display("FAIL dbz_lat: got %0d want %0d", cyc, DIV_LAT);
        end
        tick();
        checks++;
        if (lo !== DBZ || hi !== 32'h0000_1234) begin
            errors++;
            $display("FAIL dbz_divu: hi=%h lo=%h want 00001234 %h", hi, lo, DBZ);
        end
        issue(FN_DIV, 32'hFFFF_FF00, 32'h0);
        wait_done(cyc);
        tick();
        checks++;
        if (lo !== DBZ || hi !== 32'hFFFF_FF00) begin
            errors++;
            $display("FAIL dbz_div: hi=%h lo=%h want ffffff00 %h", hi, lo, DBZ);
        end
    endtask

    task automatic test_stall;
        int bad;
        req_valid = 1'b1;
        req_op = FN_DIVU;
        req_a = 32'd100;
        req_b = 32'd7;
        tick();
        req_op = FN_MFLO;
        req_a = $urandom;
        req_b = $urandom;
        bad = 0;
        for (int c = 1; c <= DIV_LAT; c++) begin
            if (stall !== 1'b1 || req_ready !== 1'b0) bad++;
            if (c == DIV_LAT && done !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_window: bad_cycles=%0d want 0", bad);
        end
        checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: ready=%b stall=%b want 1 0", req_ready, stall);
        end
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL stall_mflo: hi=%h lo=%h want 2 14", hi, lo);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_mt;
        logic [31:0] vh, vl;
        vh = $urandom;
        vl = $urandom;
        issue(FN_MTHI, vh, 32'h0);
        checks++;
        if (hi !== vh || done !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mthi: hi=%h done=%b ready=%b want %h 0 1", hi, done, req_ready, vh);
        end
        issue(FN_MTLO, vl, 32'h0);
        checks++;
        if (lo !== vl || hi !== vh) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h want %h %h", hi, lo, vh, vl);
        end
        issue(FN_MFHI, 32'h1357_9BDF, 32'h0);
        checks++;
        if (hi !== vh || lo !== vl || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mfhi_noeffect: hi=%h lo=%h ready=%b want %h %h 1", hi, lo, req_ready, vh, vl);
        end
    endtask

    task automatic test_flush;
        int seen;
        issue(FN_MTHI, 32'hAAAA_AAAA, 32'h0);
        issue(FN_MTLO, 32'h5555_5555, 32'h0);
        issue(FN_DIV, 32'h0001_0000, 32'd3);
        for (int c = 1; c < 10; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_run_idle: ready=%b want 1", req_ready);
        end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen !== 0 || hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
            errors++;
            $display("FAIL flush_run: done_cnt=%0d hi=%h lo=%h want 0 aaaaaaaa 55555555", seen, hi, lo);
        end
        issue(FN_DIVU, 32'd99, 32'd5);
        for (int c = 1; c < DIV_LAT; c++) tick();
        flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL flush_fix_done: done=%b want 0", done);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
            errors++;
            $display("FAIL flush_fix: ready=%b hi=%h lo=%h want 1 aaaaaaaa 55555555", req_ready, hi, lo);
        end
        issue(FN_MULT, 32'd6, 32'd7);
        for (int c = 1; c < MUL_LAT; c++) tick();
        flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL flush_mul_done: done=%b want 0", done);
        end
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
            errors++;
            $display("FAIL flush_mul: hi=%h lo=%h want aaaaaaaa 55555555", hi, lo);
        end
        flush = 1'b1;
        issue(FN_MTHI, 32'h1, 32'h0);
        flush = 1'b0;
        checks++;
        if (hi !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL flush_idle_mthi: hi=%h want aaaaaaaa", hi);
        end
    endtask

    task automatic test_reset_mid;
        issue(FN_MULT, 32'd5, 32'd7);
        tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hi=%h lo=%h ready=%b done=%b want 0 0 1 0", hi, lo, req_ready, done);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        issue(FN_MTLO, 32'hDEAD_BEEF, 32'h0);
        checks++;
        if (lo !== 32'hDEAD_BEEF || hi !== 32'h0) begin
            errors++;
            $display("FAIL reset_mtlo: hi=%h lo=%h want 0 deadbeef", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] tbl[4] = '{FN_MULT, FN_DIVU, FN_MULTU, FN_DIV};
        int cyc, want_lat;
        for (int i = 0; i < 8; i++) begin
            logic [5:0] op;
            logic [31:0] a, b;
            logic [63:0] exp;
            op = tbl[$urandom_range(0, 3)];
            a = $urandom;
            b = pick_b($urandom_range(0, 5));
            exp = ref_hilo(op, a, b);
            want_lat = (op == FN_MULT || op == FN_MULTU) ? MUL_LAT : DIV_LAT;
            issue(op, a, b);
            wait_done(cyc);
            tick();
            checks++;
            if (cyc !== want_lat || {hi, lo} !== exp || req_ready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b: op=%h lat=%0d hi=%h lo=%h ready=%b done=%b want lat=%0d %h 1 0",
                         op, cyc, hi, lo, req_ready, done, want_lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_dbz();
        test_stall();
        test_mt();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
